// File: rtl/rv32_barrel_hart_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_barrel_hart_sched_if
//  Purpose  : Signal bundle between the barrel hart scheduler and its
//             neighbours (execute redirect in, fetch/decode/writeback tags out)
//  Revision : 1.0  initial release
// ============================================================================
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

interface rv32_barrel_hart_sched_if #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
);
  // Control and redirect inputs to the scheduler
  logic                      stall_i;
  logic [NUM_HARTS-1:0]      hart_en_i;
  logic                      redir_valid_i;
  logic [HART_CNT_WIDTH-1:0] redir_hart_i;
  logic [`XPR_LEN-1:0]       redir_pc_i;

  // Fetch slot and delayed hart tags from the scheduler
  logic                      fetch_valid_o;
  logic [HART_CNT_WIDTH-1:0] fetch_hart_o;
  logic [`XPR_LEN-1:0]       fetch_pc_o;
  logic                      dec_valid_o;
  logic [HART_CNT_WIDTH-1:0] dec_hart_o;
  logic                      wb_valid_o;
  logic [HART_CNT_WIDTH-1:0] wb_hart_o;

  // Scheduler side
  modport master (
    input  stall_i, hart_en_i, redir_valid_i, redir_hart_i, redir_pc_i,
    output fetch_valid_o, fetch_hart_o, fetch_pc_o,
           dec_valid_o, dec_hart_o, wb_valid_o, wb_hart_o
  );

  // Pipeline / environment side
  modport slave (
    output stall_i, hart_en_i, redir_valid_i, redir_hart_i, redir_pc_i,
    input  fetch_valid_o, fetch_hart_o, fetch_pc_o,
           dec_valid_o, dec_hart_o, wb_valid_o, wb_hart_o
  );
endinterface

`default_nettype wire

// File: rtl/rv32_barrel_hart_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_barrel_hart_sched
//  Purpose  : Round-robin hart issue for the barrel core. One PC per hart,
//             one issue slot per cycle, delayed {valid,hart} tags for the
//             regfile read (decode) and write (writeback) hart selects.
//  Revision : 1.0  initial release
// ============================================================================
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module rv32_barrel_hart_sched #(
  parameter int                   NUM_HARTS      = 8,
  parameter int                   HART_CNT_WIDTH = $clog2(NUM_HARTS),
  parameter logic [`XPR_LEN-1:0]  RESET_PC       = 32'h0000_0000,
  parameter int                   DEC_LAT        = 1,
  parameter int                   WB_LAT         = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  rv32_barrel_hart_sched_if.master bus
);

  localparam int XLEN = `XPR_LEN;

  // Parameter sanity: a hart must never have two instructions in flight,
  // which is what lets redirects skip any squash logic.
  generate
    if (NUM_HARTS < WB_LAT + 1) begin : g_chk_harts
      $error("rv32_barrel_hart_sched: NUM_HARTS must be >= WB_LAT+1");
    end
    if ((NUM_HARTS & (NUM_HARTS - 1)) != 0) begin : g_chk_pow2
      $error("rv32_barrel_hart_sched: NUM_HARTS must be a power of two");
    end
    if ((DEC_LAT < 1) || (DEC_LAT > WB_LAT - 1)) begin : g_chk_dec
      $error("rv32_barrel_hart_sched: DEC_LAT must be in 1..WB_LAT-1");
    end
  endgenerate

  logic [HART_CNT_WIDTH-1:0] cur_q, cur_d;
  logic [XLEN-1:0]           pc_q [NUM_HARTS];
  logic [XLEN-1:0]           pc_d [NUM_HARTS];
  logic                      fetch_valid_q;
  logic [HART_CNT_WIDTH-1:0] fetch_hart_q;
  logic [XLEN-1:0]           fetch_pc_q;
  logic                      tag_valid_q [WB_LAT];
  logic [HART_CNT_WIDTH-1:0] tag_hart_q  [WB_LAT];

  logic w_issue;
  logic w_unused;

  assign w_issue  = ~bus.stall_i;
  // Redirect targets are word aligned; the low two bits are dropped.
  assign w_unused = ^bus.redir_pc_i[1:0];

  // Next rotation slot, wrapping the last hart back to hart 0
  always_comb begin
    cur_d = (cur_q == HART_CNT_WIDTH'(NUM_HARTS - 1)) ? '0
                                                     : cur_q + HART_CNT_WIDTH'(1);
  end

  // Per-hart next PC: +4 on an enabled issue, redirect overrides it
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      pc_d[h] = pc_q[h];
      if (w_issue && bus.hart_en_i[h] && (cur_q == HART_CNT_WIDTH'(h))) begin
        pc_d[h] = pc_q[h] + XLEN'(4);
      end
      if (bus.redir_valid_i && (bus.redir_hart_i == HART_CNT_WIDTH'(h))) begin
        pc_d[h] = {bus.redir_pc_i[XLEN-1:2], 2'b00};
      end
    end
  end

  // State update: PCs follow redirects even in stall; rotation, fetch slot
  // and tag pipeline only move on an issue cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q         <= '0;
      fetch_valid_q <= 1'b0;
      fetch_hart_q  <= '0;
      fetch_pc_q    <= RESET_PC;
      for (int h = 0; h < NUM_HARTS; h++) begin
        pc_q[h] <= RESET_PC;
      end
      for (int k = 0; k < WB_LAT; k++) begin
        tag_valid_q[k] <= 1'b0;
        tag_hart_q[k]  <= '0;
      end
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        pc_q[h] <= pc_d[h];
      end
      if (w_issue) begin
        cur_q          <= cur_d;
        fetch_hart_q   <= cur_q;
        fetch_pc_q     <= pc_q[cur_q];
        fetch_valid_q  <= bus.hart_en_i[cur_q];
        tag_valid_q[0] <= fetch_valid_q;
        tag_hart_q[0]  <= fetch_hart_q;
        for (int k = 1; k < WB_LAT; k++) begin
          tag_valid_q[k] <= tag_valid_q[k-1];
          tag_hart_q[k]  <= tag_hart_q[k-1];
        end
      end
    end
  end

  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.fetch_hart_o  = fetch_hart_q;
  assign bus.fetch_pc_o    = fetch_pc_q;
  assign bus.dec_valid_o   = tag_valid_q[DEC_LAT-1];
  assign bus.dec_hart_o    = tag_hart_q[DEC_LAT-1];
  assign bus.wb_valid_o    = tag_valid_q[WB_LAT-1];
  assign bus.wb_hart_o     = tag_hart_q[WB_LAT-1];

endmodule

`default_nettype wire

// File: doc/rv32_barrel_hart_sched.md
Name: rv32_barrel_hart_sched

Overview:
Upstream hart scheduler for the barrel core. Holds one PC per hart and issues harts in fixed round-robin order, one slot per cycle. Emits the fetch PC/hart for the instruction memory, plus delayed hart tags used as the register-file read hart (decode) and write hart (writeback). Takes branch/jump redirects from execute.

Parameters:
NUM_HARTS, 8, number of hardware threads; power of two, >= WB_LAT+1.
HART_CNT_WIDTH, $clog2(NUM_HARTS), width of hart index.
RESET_PC, 32'h0000_0000, PC loaded into every hart on reset.
DEC_LAT, 1, issue slots between fetch output and decode/regfile-read tag; 1..WB_LAT-1.
WB_LAT, 4, issue slots between fetch output and writeback/regfile-write tag.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  freezes rotation, issue and tag pipeline.
hart_en  input  NUM_HARTS  per-hart run enable; bit h gates issue of hart h.
redir_valid  input  1  redirect request from execute.
redir_hart  input  HART_CNT_WIDTH  hart being redirected.
redir_pc  input  `XPR_LEN  new PC.
fetch_valid  output  1  fetch slot carries a real instruction.
fetch_hart  output  HART_CNT_WIDTH  hart of current fetch slot.
fetch_pc  output  `XPR_LEN  PC to fetch.
dec_valid  output  1  valid bit of the decode-stage slot.
dec_hart  output  HART_CNT_WIDTH  decode-stage hart (drives regfile read-hart select).
wb_valid  output  1  valid bit of the writeback-stage slot.
wb_hart  output  HART_CNT_WIDTH  writeback-stage hart (drives regfile write-hart select).

Behaviour:
- State: rotation counter cur_q; pc_q[NUM_HARTS]; registered fetch outputs; tag shift register of {valid, hart}, WB_LAT entries.
- Reset (rst=1 at clk edge): cur_q=0, all pc_q=RESET_PC, fetch_valid=0, fetch_hart=0, fetch_pc=RESET_PC, all tag entries {0,0}. So dec_valid=0, dec_hart=0, wb_valid=0, wb_hart=0. Reset overrides stall and redirect.
- Issue cycle (stall=0):
  - fetch_hart<=cur_q; fetch_pc<=pc_q[cur_q]; fetch_valid<=hart_en[cur_q].
  - cur_q<=cur_q+1, wrapping NUM_HARTS-1 -> 0.
  - The slot is consumed even if the hart is disabled (bubble, valid=0), so rotation timing is fixed.
- PC advance: on an issue cycle with hart_en[cur_q]=1, pc_q[cur_q]<=pc_q[cur_q]+4, modulo 2^XPR_LEN (wraps at 32'hFFFF_FFFC -> 0).
- Redirect:
  - When redir_valid=1, pc_q[redir_hart]<={redir_pc[XPR_LEN-1:2],2'b00}.
  - Applied even during stall.
  - Wins over the +4 advance when redir_hart==cur_q in the same cycle.
  - The redirected PC is used at that hart's next issue slot.
  - No squash logic: NUM_HARTS>=WB_LAT+1 guarantees no same-hart instruction is in flight.
- Tag pipeline: on an issue cycle, entry0<={fetch_valid,fetch_hart} and entry k<=entry k-1.
  - dec_* = entry DEC_LAT-1; wb_* = entry WB_LAT-1.
  - Latency: a slot shown on fetch_* in issue cycle N appears on dec_* after DEC_LAT issue cycles and on wb_* after WB_LAT issue cycles.
- Stall=1: cur_q, fetch_*, and tags hold; pc_q changes only by redirect. Outputs are stable for the whole stall.
- hart_en changes take effect at the next issue slot of that hart. In-flight slots are unaffected.
- Elaboration error if NUM_HARTS < WB_LAT+1 or DEC_LAT is out of range.

Test Plan:
- Reset, hart_en=8'hFF, no stall, 16 cycles:
  - fetch_hart = 0,1..7,0,1...
  - fetch_pc = 0 for the first 8 slots, then 4 for the next 8.
  - dec_hart lags fetch_hart by 1 cycle; wb_hart lags by 4.
  - dec_valid/wb_valid first assert 1 and 4 cycles after fetch_valid.
- hart_en=8'b1010_0101: fetch_valid=1 only for harts 0,2,5,7. Harts 1,3,4,6 keep pc_q=0 after 3 rotations; hart 0 PC sequence is 0,4,8.
- Redirect hart 3 to 32'h0000_1002 while cur_q=5: hart 3's next fetch_pc=32'h0000_1000, the following one 32'h0000_1004; other harts are unaffected.
- Redirect hart 2 to 32'h200 in the same cycle hart 2 issues PC 8: the issued fetch_pc is 8, and the next hart-2 fetch_pc is 32'h200, not 12.
- Stall high for 3 cycles mid-rotation with a redirect to hart 6 during the stall: fetch_*/dec_*/wb_* are frozen. After release, rotation resumes at the next hart and hart 6 uses the redirect PC.
- Preload hart 1 PC to 32'hFFFF_FFFC via redirect, then issue twice: fetch_pc=32'hFFFF_FFFC then 0. Asserting rst mid-run clears all outputs to the reset values on the next edge.
